// File: rtl/recip_byte_sequencer_if.sv
// Byte-side and reciprocal-side signal bundle for recip_byte_sequencer.
// slave is the sequencer's view; master is the view of whatever drives it.
interface recip_byte_sequencer_if;
  logic [7:0]  i_byte;
  logic        i_strobe;
  logic        i_abs;
  logic [23:0] o_operand;
  logic        o_abs;
  logic [23:0] i_result;
  logic        i_sat;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_overrun;

  modport slave (
    input  i_byte, i_strobe, i_abs, i_result, i_sat, i_ready,
    output o_operand, o_abs, o_byte, o_valid, o_busy, o_overrun
  );

  modport master (
    output i_byte, i_strobe, i_abs, i_result, i_sat, i_ready,
    input  o_operand, o_abs, o_byte, o_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/recip_byte_sequencer.sv
// recip_byte_sequencer: gathers a 24-bit operand from three MSB-first bytes,
// lets the combinational reciprocal unit settle for LATENCY edges, captures
// its result, then returns three result bytes plus a status byte under a
// valid/ready handshake.
module recip_byte_sequencer #(
  parameter int unsigned LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  recip_byte_sequencer_if.slave bus
);

  localparam logic [3:0] LATENCY_COUNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  state_t      state_reg,   state_next;
  logic [1:0]  index_reg,   index_next;
  logic [3:0]  count_reg,   count_next;
  logic [23:0] operand_reg, operand_next;
  logic        abs_reg,     abs_next;
  logic [31:0] result_reg,  result_next;
  logic        overrun_reg, overrun_next;

  // Result register split into its four output bytes, index 0 first.
  logic [7:0] result_bytes [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_result_bytes
    assign result_bytes[gi] = result_reg[31 - 8*gi -: 8];
  end

  logic valid;
  assign valid         = (state_reg == UNLOAD);
  assign bus.o_valid   = valid;
  assign bus.o_busy    = (state_reg != LOAD);
  // Held at zero outside UNLOAD so no stale result byte is ever presented.
  assign bus.o_byte    = valid ? result_bytes[index_reg] : 8'h00;
  assign bus.o_operand = operand_reg;
  assign bus.o_abs     = abs_reg;
  assign bus.o_overrun = overrun_reg;

  // State register; every field returns to its idle value on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      index_reg   <= 2'd0;
      count_reg   <= 4'd0;
      operand_reg <= 24'd0;
      abs_reg     <= 1'b0;
      result_reg  <= 32'd0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      count_reg   <= count_next;
      operand_reg <= operand_next;
      abs_reg     <= abs_next;
      result_reg  <= result_next;
      overrun_reg <= overrun_next;
    end
  end

  // Next-state logic: byte loading, settle countdown, byte unloading.
  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    count_next   = count_reg;
    operand_next = operand_reg;
    abs_next     = abs_reg;
    result_next  = result_reg;
    overrun_next = overrun_reg;

    case (state_reg)
      LOAD: begin
        if (bus.i_strobe) begin
          operand_next = {operand_reg[15:0], bus.i_byte};
          if (index_reg == 2'd0) begin
            abs_next = bus.i_abs;
          end
          if (index_reg == 2'd2) begin
            index_next = 2'd0;
            count_next = LATENCY_COUNT;
            state_next = WAIT;
          end else begin
            index_next = index_reg + 2'd1;
          end
        end
      end

      WAIT: begin
        count_next = count_reg - 4'd1;
        if (bus.i_strobe) begin
          overrun_next = 1'b1;
        end
        // <= rather than == so an out-of-range LATENCY of 0 cannot hang here.
        if (count_reg <= 4'd1) begin
          result_next = {bus.i_result, bus.i_sat, 6'b000000, abs_reg};
          index_next  = 2'd0;
          state_next  = UNLOAD;
        end
      end

      UNLOAD: begin
        // A strobe coinciding with the final handshake still lands here.
        if (bus.i_strobe) begin
          overrun_next = 1'b1;
        end
        if (bus.i_ready) begin
          if (index_reg == 2'd3) begin
            index_next = 2'd0;
            state_next = LOAD;
          end else begin
            index_next = index_reg + 2'd1;
          end
        end
      end

      default: begin
        index_next = 2'd0;
        state_next = LOAD;
      end
    endcase
  end

endmodule

// File: doc/recip_byte_sequencer.md
Name: recip_byte_sequencer

Overview:
Byte-wide front/back end for the combinational 24-bit fixed-point reciprocal unit.
- Assembles a 24-bit operand from three 8-bit input beats and presents it, with the abs-mode flag, to the reciprocal unit.
- Waits a programmable settle time, captures the 24-bit result and saturation flag, then returns them as four output bytes under a valid/ready handshake.
- Sits between the 8-bit chip pins and the reciprocal unit: upstream of the unit's data input, downstream of its data output.

Parameters:
- LATENCY, 1, number of clock edges between operand completion and result capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_byte  in  8  operand byte, MSB-first order.
- i_strobe  in  1  i_byte is valid this cycle.
- i_abs  in  1  abs-mode request; sampled together with the first operand byte.
- o_operand  out  24  assembled operand; drives the reciprocal data input.
- o_abs  out  1  latched abs mode; drives the reciprocal abs input.
- i_result  in  24  reciprocal data output.
- i_sat  in  1  reciprocal saturation flag.
- o_byte  out  8  result/status byte.
- o_valid  out  1  o_byte is valid.
- i_ready  in  1  consumer accepts o_byte when o_valid is also high.
- o_busy  out  1  high in WAIT and UNLOAD.
- o_overrun  out  1  sticky: a strobe arrived outside LOAD.

Behaviour:
Reset values (rst_n low at an edge; all state returns to these regardless of current state):
- state=LOAD, byte index=0
- o_operand=0, o_abs=0, result register=0, o_byte=0
- o_valid=0, o_busy=0, o_overrun=0

LOAD:
- On each edge with i_strobe=1: o_operand <= {o_operand[15:0], i_byte}; index increments.
- On index 0 only, o_abs <= i_abs.
- On the third strobe (index 2): index clears, wait counter loads LATENCY, state -> WAIT.
- The partial operand is visible on o_operand during LOAD; the downstream unit is combinational, so this is harmless.

WAIT:
- Counter decrements every edge.
- On the edge where the counter equals 1:
  - result register <= {i_result, i_sat, 6'b0, o_abs}
  - state -> UNLOAD, index=0
- Result is captured exactly LATENCY edges after the edge that took the third byte.

UNLOAD:
- o_valid=1. o_byte is, in index order:
  - index 0: result[23:16]
  - index 1: result[15:8]
  - index 2: result[7:0]
  - index 3: status byte {sat, 6'b0, abs}
- o_byte must be stable while o_valid=1 and i_ready=0.
- Each edge with o_valid && i_ready advances the index.
- After the status byte is accepted: state -> LOAD, o_valid=0 on the next cycle, index=0.
- o_operand and o_abs hold their values until the next first byte arrives.

Overrun:
- i_strobe=1 in WAIT or UNLOAD: the byte is dropped and o_overrun <= 1.
- No other state changes. o_overrun clears only on reset.

Simultaneous events:
- The handshake of the last status byte and an i_strobe in the same cycle: the strobe counts as overrun and is dropped. LOAD begins the following cycle.
- i_ready while o_valid=0: ignored.

Widths:
- No arithmetic beyond the index and wait counters.
- The wait counter is 4 bits; the byte index is 2 bits and wraps only through explicit clear.

Test Plan:
- Basic, LATENCY=1: strobe bytes 0x00,0x10,0x00 with i_abs=1 on the first; model i_result = 0x001000, i_sat=0; i_ready tied 1.
  -> o_operand=0x001000 and o_abs=1 after the third edge.
  -> o_valid rises 1 cycle later; bytes 0x00,0x10,0x00,0x01 on consecutive cycles; then o_valid=0 and o_busy=0.
- Saturation: operand bytes 0x00,0x00,0x01; model i_result = 0x7FFFFF, i_sat=1, i_abs=0.
  -> output bytes 0x7F,0xFF,0xFF,0x80.
- Backpressure: hold i_ready=0 for 5 cycles during index 1, then raise it.
  -> o_byte stays 0x10 and o_valid stays 1 throughout; sequence then resumes without loss or duplication.
- LATENCY=3: third byte taken at edge N; i_result changes value at edges N+1 and N+2 and settles to 0x000800 before edge N+3.
  -> captured value is 0x000800; o_valid rises only after edge N+3.
- Overrun: strobe 0xAA during WAIT and again during UNLOAD.
  -> o_overrun=1 and stays 1; o_operand unchanged; output sequence unaffected; the next transaction loads normally.
- Reset mid-operation: assert rst_n=0 for one edge during UNLOAD index 2.
  -> all outputs at reset values on the next cycle.
  -> a fresh 3-byte load then behaves exactly as in the basic case; no stale result bytes appear.
